// File: rtl/adder_share_pkg.sv
// Shared types and the rotating priority pick used by the adder-sharing arbiter.
// rr_pick works on the widest supported request vector; callers zero-extend.
package adder_share_pkg;

   localparam int MAX_NREQ = 8;
   localparam int MAX_IDW  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic               found;
      logic [MAX_IDW-1:0] idx;
   } pick_t;

   // Scans ptr, ptr+1, ... wrapping at nreq; the first asserted request wins.
   // Iterating from the far end lets the nearest hit overwrite earlier ones.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                     input logic [MAX_IDW-1:0]  ptr,
                                     input int                  nreq);
      pick_t p;
      int    j;
      p = '0;
      for (int k = MAX_NREQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            j = int'(ptr) + k;
            if (j >= nreq) j = j - nreq;
            if (req[j[2:0]]) begin
               p.found = 1'b1;
               p.idx   = j[2:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick_comb.sv
// Combinational round-robin picker: rotate from i_ptr and priority-encode.
// Usable by any arbiter with up to eight requesters.
module rr_pick_comb
   import adder_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic            o_found,
   output logic [IDW-1:0]  o_idx
);

   logic [MAX_NREQ-1:0] w_req;
   logic [MAX_IDW-1:0]  w_ptr;
   pick_t               w_pick;

   assign w_req   = MAX_NREQ'(i_req);
   assign w_ptr   = MAX_IDW'(i_ptr);
   assign w_pick  = rr_pick(w_req, w_ptr, NREQ);
   assign o_found = w_pick.found;
   assign o_idx   = IDW'(w_pick.idx);

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one registered x+y adder among NREQ requesters;
// the single result register is tagged with the winner's index.
//
// Handshake: o/o_id are meaningful while o_valid=1 and stay frozen until an
// edge with o_ack=1 consumes them; o_ack with o_valid=0 has no effect.
// Requests are sampled only in IDLE, so a requester holds req and operands
// until it sees its one-cycle gnt pulse.
module adder_share_arb
   import adder_share_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 1,
   parameter int IDW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   output logic [NREQ-1:0]   gnt,
   output logic [WIDTH-1:0]  o,
   output logic              o_valid,
   output logic [IDW-1:0]    o_id,
   input  logic              o_ack,
   output logic              o_dbg_busy
);

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [NREQ-1:0]  r_gnt;
   logic [WIDTH-1:0] r_o;
   logic             r_valid;
   logic [IDW-1:0]   r_id;

   logic             w_found;
   logic [IDW-1:0]   w_win;
   logic [WIDTH-1:0] w_sum;
   logic [NREQ-1:0]  w_onehot;
   logic [IDW-1:0]   w_ptr_nxt;

   rr_pick_comb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_win)
   );

   // Sum is WIDTH bits wide, so the carry out is dropped by construction.
   assign w_sum     = req_x[int'(w_win)*WIDTH +: WIDTH] + req_y[int'(w_win)*WIDTH +: WIDTH];
   assign w_onehot  = NREQ'(1) << w_win;
   assign w_ptr_nxt = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_o     <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_gnt <= '0;
               if (w_found) begin
                  r_o     <= w_sum;
                  r_id    <= w_win;
                  r_valid <= 1'b1;
                  r_gnt   <= w_onehot;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_gnt <= '0;
               if (o_ack) begin
                  r_valid <= 1'b0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign o          = r_o;
   assign o_valid    = r_valid;
   assign o_id       = r_id;
   assign o_dbg_busy = (r_state == BUSY);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: a cycle table on a WIDTH=1 instance, directed
// corner cases and randomized traffic on a WIDTH=4 instance.
module tb_adder_share_arb;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int WA  = 1;
   localparam int WB  = 4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst, b_rst;

   // instance A (WIDTH=1)
   logic [N-1:0]    a_req;
   logic [N*WA-1:0] a_x, a_y;
   logic [N-1:0]    a_gnt;
   logic [WA-1:0]   a_o;
   logic            a_v, a_ack, a_busy;
   logic [IDW-1:0]  a_id;

   // instance B (WIDTH=4)
   logic [N-1:0]    b_req;
   logic [N*WB-1:0] b_x, b_y;
   logic [N-1:0]    b_gnt;
   logic [WB-1:0]   b_o;
   logic            b_v, b_ack, b_busy;
   logic [IDW-1:0]  b_id;

   adder_share_arb #(.NREQ(N), .WIDTH(WA), .IDW(IDW)) dut_a (
      .clk(clk), .rst(a_rst), .req(a_req), .req_x(a_x), .req_y(a_y),
      .gnt(a_gnt), .o(a_o), .o_valid(a_v), .o_id(a_id), .o_ack(a_ack),
      .o_dbg_busy(a_busy)
   );

   adder_share_arb #(.NREQ(N), .WIDTH(WB), .IDW(IDW)) dut_b (
      .clk(clk), .rst(b_rst), .req(b_req), .req_x(b_x), .req_y(b_y),
      .gnt(b_gnt), .o(b_o), .o_valid(b_v), .o_id(b_id), .o_ack(b_ack),
      .o_dbg_busy(b_busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cycle table for instance A: inputs before an edge, outputs after it
   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic         ack;
      logic [N-1:0] e_gnt;
      logic         e_o;
      logic         e_v;
      logic [1:0]   e_id;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic r, input logic [3:0] rq, input logic [3:0] x, input logic [3:0] y,
                    input logic ak, input logic [3:0] g, input logic eo, input logic ev, input logic [1:0] id);
      vec_t t;
      t.rst = r; t.req = rq; t.x = x; t.y = y; t.ack = ak;
      t.e_gnt = g; t.e_o = eo; t.e_v = ev; t.e_id = id;
      tbl.push_back(t);
   endtask

   // scoreboard / reference model state for instance B
   logic [IDW+WB-1:0] exp_q[$];
   int m_ptr, m_id, m_o, m_busy, m_gnt;

   task automatic model_cycle();
      int w;
      m_gnt = 0;
      if (b_rst) begin
         m_ptr = 0; m_busy = 0; m_o = 0; m_id = 0;
         exp_q.delete();
      end else if (m_busy != 0) begin
         if (b_ack) begin
            m_busy = 0;
            m_ptr  = (m_id + 1) % N;
            void'(exp_q.pop_front());
         end
      end else begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            if (w < 0 && b_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
         if (w >= 0) begin
            m_o    = (int'(b_x[w*WB +: WB]) + int'(b_y[w*WB +: WB])) % (1 << WB);
            m_id   = w;
            m_busy = 1;
            m_gnt  = 1 << w;
            exp_q.push_back({2'(m_id), 4'(m_o)});
         end
      end
   endtask

   initial begin
      a_rst = 1'b1; a_req = 4'b1111; a_x = '0; a_y = '0; a_ack = 1'b0;
      b_rst = 1'b1; b_req = '0;      b_x = '0; b_y = '0; b_ack = 1'b0;

      // reset held two cycles with every request asserted
      for (int c = 0; c < 2; c++) begin
         step();
         chk("rst gnt", 32'(a_gnt), 0);
         chk("rst o_valid", 32'(a_v), 0);
         chk("rst o", 32'(a_o), 0);
         chk("rst o_id", 32'(a_id), 0);
         chk("rst busy", 32'(a_busy), 0);
      end

      //  rst req     x       y       ack gnt     o  v  id
      v(0, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 0);
      v(0, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      v(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0100, 0, 1, 2);
      v(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 2);
      v(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0100, 0, 1, 2);
      v(0, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 2);
      v(1, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 0, 0, 0);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0001, 0, 1, 0);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 0, 0, 0);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0010, 0, 1, 1);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 0, 0, 1);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0100, 1, 1, 2);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 1, 0, 2);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b1000, 1, 1, 3);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 1, 0, 3);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0001, 0, 1, 0);
      v(0, 4'b1111, 4'b1010, 4'b0110, 1, 4'b0000, 0, 0, 0);
      v(0, 4'b0010, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1);
      for (int c = 0; c < 5; c++)
         v(0, 4'b1011, 4'b0010, 4'b0000, 0, 4'b0000, 1, 1, 1);
      v(0, 4'b1011, 4'b0010, 4'b0000, 1, 4'b0000, 1, 0, 1);
      v(0, 4'b1011, 4'b0010, 4'b0000, 0, 4'b1000, 0, 1, 3);
      v(1, 4'b1001, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0);
      v(0, 4'b1001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0);
      v(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0000, 1, 0, 0);
      v(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0000, 1, 0, 0);

      foreach (tbl[i]) begin
         a_rst = tbl[i].rst; a_req = tbl[i].req; a_x = tbl[i].x; a_y = tbl[i].y; a_ack = tbl[i].ack;
         step();
         chk($sformatf("row%0d gnt", i),   32'(a_gnt),  32'(tbl[i].e_gnt));
         chk($sformatf("row%0d o", i),     32'(a_o),    32'(tbl[i].e_o));
         chk($sformatf("row%0d valid", i), 32'(a_v),    32'(tbl[i].e_v));
         chk($sformatf("row%0d id", i),    32'(a_id),   32'(tbl[i].e_id));
         chk($sformatf("row%0d busy", i),  32'(a_busy), 32'(tbl[i].e_v));
      end
      a_req = '0; a_ack = 1'b0;

      // WIDTH=4: F + 2 wraps to 1
      b_rst = 1'b0;
      b_req = 4'b0001; b_x = 16'h000F; b_y = 16'h0002; b_ack = 1'b0;
      step();
      chk("w4 gnt", 32'(b_gnt), 1);
      chk("w4 o", 32'(b_o), 1);
      chk("w4 id", 32'(b_id), 0);
      chk("w4 valid", 32'(b_v), 1);
      b_req = '0; b_ack = 1'b1;
      step();
      chk("w4 ack valid", 32'(b_v), 0);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("idle ack o", 32'(b_o), 1);
         chk("idle ack id", 32'(b_id), 0);
         chk("idle ack valid", 32'(b_v), 0);
         chk("idle ack gnt", 32'(b_gnt), 0);
      end

      // randomized traffic against the reference model
      m_ptr = 1; m_busy = 0; m_o = 1; m_id = 0; m_gnt = 0;
      for (int c = 0; c < 400; c++) begin
         b_rst = ($urandom_range(0, 63) == 0);
         b_req = 4'($urandom_range(0, 15));
         b_x   = 16'($urandom);
         b_y   = 16'($urandom);
         b_ack = ($urandom_range(0, 3) != 0);
         model_cycle();
         step();
         chk($sformatf("rnd%0d gnt", c), 32'(b_gnt), 32'(m_gnt));
         chk($sformatf("rnd%0d valid", c), 32'(b_v), 32'(m_busy));
         if (exp_q.size() > 0)
            chk($sformatf("rnd%0d result", c), 32'({b_id, b_o}), 32'(exp_q[0]));
         else
            chk($sformatf("rnd%0d held", c), 32'({b_id, b_o}), 32'({2'(m_id), 4'(m_o)}));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter/sequencer sharing one registered x+y adder slice (WIDTH-bit, modulo 2^WIDTH) among NREQ requesters.
- Replaces several adder instances driving one result net with a single owned result register.
- Result is tagged with the winner's index.
- The result is held under a valid/ack handshake until it is consumed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 1, operand and result width in bits.
- IDW, 2, index width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_x  in  NREQ*WIDTH  operand x; slice i = bits [i*WIDTH +: WIDTH].
- req_y  in  NREQ*WIDTH  operand y; same slicing as req_x.
- gnt  out  NREQ  one-hot grant pulse.
- o  out  WIDTH  registered sum.
- o_valid  out  1  result valid.
- o_id  out  IDW  index of the requester that owns o.
- o_ack  in  1  consumer accepts o.

Behaviour:
- Reset: all outputs and state are set at the rst clock edge.
  - state=IDLE, ptr=0.
  - gnt=0, o=0, o_valid=0, o_id=0.
  - rst has priority over every other event.
- States: IDLE, BUSY. All outputs are registered.
- IDLE, edge where |req=1:
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - o <= (req_x[w] + req_y[w]) mod 2^WIDTH; the carry is discarded.
  - o_id <= w; o_valid <= 1; gnt <= one-hot(w); state <= BUSY.
- IDLE with req=0: all registers hold; gnt=0.
- BUSY:
  - gnt returns to 0 one cycle after assertion, so gnt is a one-cycle pulse.
  - o, o_id and o_valid=1 are held stable until an edge with o_ack=1.
  - At that edge: o_valid <= 0; ptr <= (o_id+1) mod NREQ; state <= IDLE.
- Latency: operands are sampled at capture edge N.
  - gnt, o and o_valid are visible in cycle N+1.
  - If o_ack=1 in cycle N+1, the next capture is at edge N+2.
  - Peak throughput is one result per 2 cycles.
- Requests during BUSY are not sampled. Requesters hold req and operands until their gnt. A req dropped before gnt is lost with no side effect.
- o_ack while o_valid=0 is ignored.
- Fairness: a requester that holds req continuously is granted within NREQ arbitrations.
- Single requester: granted every arbitration.
- All requesters asserted: grants rotate 0,1,2,…,NREQ-1,0.
- Reset mid-BUSY: the pending result is discarded and ptr returns to 0.
- Operands are never X-propagated into state: o is loaded only at a capture edge.

Decomposition:
- Shared package adder_share_pkg:
  - state enum (IDLE, BUSY).
  - function rr_pick(req, ptr), returning the winner index and a found flag.
- One natural sub-module: rr_pick_comb (NREQ, IDW). Purely combinational rotate-and-priority-encode; reusable by other arbiters.
- The adder is inline: one expression, no sub-module.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=4'b1111 → gnt=0, o_valid=0, o=0, o_id=0. After release, first grant goes to index 0.
- Single request, WIDTH=1: req=4'b0100, x2=1, y2=1, o_ack tied 1.
  - Cycle after capture: gnt=4'b0100, o=0 (carry dropped), o_id=2, o_valid=1.
  - Next capture is 2 cycles later.
- Round robin: req=4'b1111 held, o_ack=1 → o_id sequence 0,1,2,3,0 on successive results; gnt is one-hot and one cycle wide each time.
- Backpressure: grant requester 1 with x=1, y=0, then hold o_ack=0 for 5 cycles while req=4'b1011.
  - o=1, o_id=1 and o_valid=1 stay stable; no further gnt.
  - o_ack=1 → next winner is 3.
- Reset mid-BUSY: rst=1 while o_valid=1, o_id=3 → o_valid=0, o_id=0, ptr=0. With req=4'b1001, the next grant goes to 0.
- WIDTH=4 variant: x0=4'hF, y0=4'h2 → o=4'h1. Also check that a spurious o_ack while IDLE leaves all outputs unchanged.
